mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- MEM-stage sequencer for the LC-3b pipeline; executes decoded memory opcodes as multi-cycle transactions on the data-memory handshake port.
- Generalises the current single-access LDR/STR handling in three ways: true two-phase indirection for LDI/STI, byte-lane steering for LDB/STB, and parametrised data width with a response timeout.
- Holds the pipeline through a stall output until the transaction retires.

Parameters:
- DATA_WIDTH, 16, memory word width in bits; legal values 16 or 32. NB = DATA_WIDTH/8 byte lanes; LB = log2(NB).
- ADDR_WIDTH, 16, byte-address width.
- WAIT_LIMIT, 64, maximum cycles to wait for dmem_resp per phase; 0 disables the timeout.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  valid instruction present in MEM stage
- opcode  in  4  lc3b_opcode of that instruction
- addr  in  ADDR_WIDTH  effective byte address from the address adder
- wdata  in  DATA_WIDTH  store data (SR)
- dmem_addr  out  ADDR_WIDTH  memory address
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_byte_enable  out  NB  write lane mask
- dmem_wdata  out  DATA_WIDTH  memory write data
- dmem_rdata  in  DATA_WIDTH  memory read data
- dmem_resp  in  1  one-cycle completion pulse for the current request
- rdata_out  out  DATA_WIDTH  load result for regfile writeback
- done  out  1  one-cycle retire pulse
- stall  out  1  freeze upstream pipeline stages
- err  out  1  timeout flag, valid while done=1

Behaviour:
- Reset (asynchronous, while reset_n=0): state=IDLE; all outputs 0; wait counter, pointer register and rdata_out cleared. Reset during an active transaction abandons it with no completion pulse; dmem_read and dmem_write drop immediately.
- Memory opcodes: LDR, LDB, LDI, STR, STB, STI. All other opcodes are non-memory.
- IDLE:
  - start with a memory opcode: capture opcode, addr and wdata; go to PH1.
  - start with a non-memory opcode: go to DONE; no memory request is issued.
  - stall = start & memory opcode, combinationally in IDLE.
- PH1:
  - Word ops (LDR, LDI, STR, STI): dmem_addr = addr with its low LB bits forced to 0.
  - Byte ops (LDB, STB): dmem_addr = addr as captured.
  - dmem_read=1 for LDR, LDB, LDI and STI; dmem_write=1 for STR and STB.
  - Requests stay asserted, with address and data stable, until dmem_resp.
  - On dmem_resp:
    - LDI/STI: latch dmem_rdata as the pointer; go to PH2.
    - LDR: rdata_out = dmem_rdata; go to DONE.
    - LDB: rdata_out = zero-extended byte from lane addr[LB-1:0]; go to DONE.
    - Stores: go to DONE.
- PH2:
  - dmem_addr = pointer with its low LB bits forced to 0.
  - LDI asserts dmem_read; on dmem_resp, rdata_out = dmem_rdata.
  - STI asserts dmem_write with full lanes and dmem_wdata = wdata.
  - On dmem_resp, go to DONE.
- Write lanes:
  - Word stores: dmem_byte_enable = all ones.
  - STB: only bit addr[LB-1:0] is set, and wdata[7:0] is replicated into every lane.
  - Reads: dmem_byte_enable = 0.
- DONE: done=1 and stall=0 for one cycle; return to IDLE. A start seen in DONE is ignored; upstream re-presents it in IDLE on the next cycle.
- stall = 1 throughout PH1 and PH2.
- Between DONE and the next LDR/LDB/LDI, rdata_out holds its last value.
- Timeout:
  - A counter resets on entry to each phase and increments every cycle without dmem_resp.
  - When WAIT_LIMIT != 0 and the counter reaches WAIT_LIMIT: drop requests, go to DONE with err=1, leave rdata_out unchanged.
  - Otherwise err=0.
- Simultaneous events:
  - dmem_resp in the same cycle the counter reaches WAIT_LIMIT: treat as success.
  - dmem_resp in IDLE or DONE: ignored.
  - start and opcode are ignored outside IDLE.
- Latency (dmem_resp returned the cycle after the request):
  - Single-phase op: done 3 cycles after start.
  - LDI/STI: done 5 cycles after start.
  - Non-memory op: done 1 cycle after start.

Test Plan:
- LDR, addr=0x1235, memory returns 0xBEEF after 2 wait cycles -> dmem_addr=0x1234 with dmem_read held 3 cycles; rdata_out=0xBEEF; done pulses once; err=0.
- STB, addr=0x0101, wdata=0x00A5 (DATA_WIDTH=16) -> dmem_byte_enable=2'b10, dmem_wdata=0xA5A5, dmem_write=1; stall low only in DONE.
- LDB, addr=0x2001, memory word 0x7F80 -> rdata_out=0x007F.
- LDI, addr=0x3000, mem[0x3000]=0x4002, mem[0x4002]=0x1111 -> reads 0x3000 then 0x4002; rdata_out=0x1111; done 5 cycles after start with 1-cycle responses.
- STI, addr=0x3000, pointer 0x5003, wdata=0x2222 -> read 0x3000, then write 0x5002 with lanes 2'b11 and data 0x2222.
- WAIT_LIMIT=4 with no dmem_resp -> requests drop after 4 cycles; done=1 with err=1.
- Reset asserted mid-PH2 of LDI -> outputs go to 0 immediately with no done pulse; the next start proceeds normally.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// MEM-stage sequencer for LC-3b loads/stores: one- or two-phase transactions on the
// data-memory handshake port, with byte-lane steering and a per-phase response timeout.
module mem_access_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int WAIT_LIMIT = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [3:0]              opcode,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [ADDR_WIDTH-1:0]   dmem_addr,
    output logic                    dmem_read,
    output logic                    dmem_write,
    output logic [DATA_WIDTH/8-1:0] dmem_byte_enable,
    output logic [DATA_WIDTH-1:0]   dmem_wdata,
    input  logic [DATA_WIDTH-1:0]   dmem_rdata,
    input  logic                    dmem_resp,
    output logic [DATA_WIDTH-1:0]   rdata_out,
    output logic                    done,
    output logic                    stall,
    output logic                    err
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    localparam logic [3:0] OP_LDB = 4'd2;
    localparam logic [3:0] OP_STB = 4'd3;
    localparam logic [3:0] OP_LDR = 4'd6;
    localparam logic [3:0] OP_STR = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd10;
    localparam logic [3:0] OP_STI = 4'd11;

    typedef enum logic [1:0] {IDLE, PH1, PH2, DONE} state_t;

    typedef struct packed {
        logic [3:0]            op;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    state_t                state, state_nxt;
    req_t                  req;
    logic [DATA_WIDTH-1:0] ptr;
    logic [CW-1:0]         wait_cnt;
    logic                  err_q;

    logic                  in_phase, timeout, is_byte, is_ind;
    logic [LB-1:0]         lane;
    logic [ADDR_WIDTH-1:0] ptr_addr, req_word, ptr_word;

    function automatic logic is_mem(input logic [3:0] op);
        return op inside {OP_LDB, OP_STB, OP_LDR, OP_STR, OP_LDI, OP_STI};
    endfunction

    assign lane     = req.addr[LB-1:0];
    assign is_byte  = req.op inside {OP_LDB, OP_STB};
    assign is_ind   = req.op inside {OP_LDI, OP_STI};
    assign ptr_addr = ADDR_WIDTH'(ptr);
    assign req_word = {req.addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
    assign ptr_word = {ptr_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
    assign in_phase = (state == PH1) || (state == PH2);
    // A response in the final allowed cycle wins over the timeout.
    assign timeout  = (WAIT_LIMIT != 0) && in_phase && !dmem_resp &&
                      (wait_cnt == CW'(WAIT_LIMIT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = is_mem(opcode) ? PH1 : DONE;
            PH1:  if (dmem_resp) state_nxt = is_ind ? PH2 : DONE;
                  else if (timeout) state_nxt = DONE;
            PH2:  if (dmem_resp || timeout) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req       <= '0;
            ptr       <= '0;
            rdata_out <= '0;
            wait_cnt  <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state == IDLE && start && is_mem(opcode))
                req <= {opcode, addr, wdata};
            // Cleared on every phase exit, so each phase starts counting from zero.
            if (in_phase && !dmem_resp && !timeout) wait_cnt <= wait_cnt + CW'(1);
            else                                    wait_cnt <= '0;
            if (in_phase)           err_q <= timeout;
            else if (state == IDLE) err_q <= 1'b0;
            if (state == PH1 && dmem_resp) begin
                case (req.op)
                    OP_LDI, OP_STI: ptr       <= dmem_rdata;
                    OP_LDR:         rdata_out <= dmem_rdata;
                    OP_LDB:         rdata_out <= DATA_WIDTH'(dmem_rdata[{lane, 3'b000} +: 8]);
                    default: ;
                endcase
            end
            if (state == PH2 && dmem_resp && req.op == OP_LDI)
                rdata_out <= dmem_rdata;
        end
    end

    always_comb begin
        dmem_addr        = '0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_byte_enable = '0;
        dmem_wdata       = '0;
        done             = 1'b0;
        stall            = 1'b0;
        err              = 1'b0;
        case (state)
            IDLE: stall = reset_n && start && is_mem(opcode);
            PH1: begin
                stall      = 1'b1;
                dmem_addr  = is_byte ? req.addr : req_word;
                dmem_read  = req.op inside {OP_LDR, OP_LDB, OP_LDI, OP_STI};
                dmem_write = req.op inside {OP_STR, OP_STB};
                if (req.op == OP_STR) begin
                    dmem_byte_enable = '1;
                    dmem_wdata       = req.wdata;
                end else if (req.op == OP_STB) begin
                    dmem_byte_enable = NB'(1) << lane;
                    dmem_wdata       = {NB{req.wdata[7:0]}};
                end
            end
            PH2: begin
                stall      = 1'b1;
                dmem_addr  = ptr_word;
                dmem_read  = (req.op == OP_LDI);
                dmem_write = (req.op == OP_STI);
                if (req.op == OP_STI) begin
                    dmem_byte_enable = '1;
                    dmem_wdata       = req.wdata;
                end
            end
            DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: a transaction-level model predicts bus
// accesses and retire results; a memory responder and a retire monitor check them.
module tb_mem_access_sequencer;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int WL = 4;
    localparam logic [3:0] LDB = 4'd2, STB = 4'd3, LDR = 4'd6, STR = 4'd7, LDI = 4'd10, STI = 4'd11;

    logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [3:0]    opcode = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] dmem_addr;
    logic          dmem_read, dmem_write;
    logic [1:0]    dmem_byte_enable;
    logic [DW-1:0] dmem_wdata, dmem_rdata = '0;
    logic          dmem_resp = 1'b0;
    logic [DW-1:0] rdata_out;
    logic          done, stall, err;

    mem_access_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .addr(addr),
        .wdata(wdata), .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp), .rdata_out(rdata_out), .done(done), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic          wr;
        logic [1:0]    be;
        logic [DW-1:0] d;
    } acc_t;
    typedef struct packed {
        logic [DW-1:0] rd;
        logic          err;
    } res_t;

    acc_t          acc_q[$];
    int            lat_q[$];
    res_t          res_q[$];
    logic [DW-1:0] ref_mem [0:32767];
    logic [DW-1:0] bus_mem [0:32767];
    logic [DW-1:0] prev_rd = '0;
    int            n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_mem_op(input logic [3:0] op);
        return op == LDB || op == STB || op == LDR || op == STR || op == LDI || op == STI;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [1:0] be);
        return {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
    endfunction

    function automatic int pick_lat();
        int r = $urandom_range(0, 9);
        return (r < 8) ? r % 4 : 4 + r % 2;
    endfunction

    task automatic setmem(input logic [AW-1:0] a, input logic [DW-1:0] v);
        ref_mem[a[AW-1:1]] = v;
        bus_mem[a[AW-1:1]] = v;
    endtask

    // Transaction-level prediction: bus accesses, their latencies, retire result and cycle count.
    task automatic model(input logic [3:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input int l1, input int l2, output int exp_lat);
        acc_t x;
        logic [DW-1:0] w, rd;
        logic e;
        rd = prev_rd; e = 1'b0; exp_lat = 1;
        if (is_mem_op(op)) begin
            x.a  = (op == LDB || op == STB) ? a : {a[AW-1:1], 1'b0};
            x.wr = (op == STR || op == STB);
            x.be = (op == STR) ? 2'b11 : (op == STB) ? (a[0] ? 2'b10 : 2'b01) : 2'b00;
            x.d  = (op == STR) ? wd : (op == STB) ? {wd[7:0], wd[7:0]} : '0;
            acc_q.push_back(x); lat_q.push_back(l1);
            if (l1 >= WL) begin
                e = 1'b1; exp_lat = 1 + WL;
            end else begin
                exp_lat = l1 + 2;
                w = ref_mem[x.a[AW-1:1]];
                if (x.wr) ref_mem[x.a[AW-1:1]] = merge(w, x.d, x.be);
                if (op == LDR) rd = w;
                if (op == LDB) rd = a[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
                if (op == LDI || op == STI) begin
                    x.a  = {w[AW-1:1], 1'b0};
                    x.wr = (op == STI);
                    x.be = (op == STI) ? 2'b11 : 2'b00;
                    x.d  = (op == STI) ? wd : '0;
                    acc_q.push_back(x); lat_q.push_back(l2);
                    if (l2 >= WL) begin
                        e = 1'b1; exp_lat += WL;
                    end else begin
                        exp_lat += l2 + 1;
                        if (op == STI) ref_mem[x.a[AW-1:1]] = wd;
                        else           rd = ref_mem[x.a[AW-1:1]];
                    end
                end
            end
        end
        res_q.push_back({rd, e});
        prev_rd = rd;
    endtask

    // Memory responder: checks each request against the predicted access, then answers after its latency.
    acc_t cur;
    int   cur_lat, cur_cnt;
    bit   busy = 1'b0;
    always begin
        acc_t act;
        @(posedge clk); #1;
        dmem_resp  = 1'b0;
        dmem_rdata = DW'($urandom);
        if (reset_n && (dmem_read || dmem_write)) begin
            act = {dmem_addr, dmem_write, dmem_byte_enable, dmem_write ? dmem_wdata : 16'h0};
            if (!busy) begin
                busy = 1'b1; cur_cnt = 0;
                if (acc_q.size() == 0) begin
                    chk("unexpected_request", 1, 0);
                    cur = act; cur_lat = 0;
                end else begin
                    cur = acc_q.pop_front(); cur_lat = lat_q.pop_front();
                    chk("request", act, cur);
                    chk("request_read", dmem_read, !cur.wr);
                end
            end else begin
                chk("request_stable", act, cur);
            end
            if (cur_cnt == cur_lat) begin
                dmem_resp = 1'b1;
                if (dmem_write) bus_mem[dmem_addr[AW-1:1]] = merge(bus_mem[dmem_addr[AW-1:1]], dmem_wdata, dmem_byte_enable);
                else            dmem_rdata = bus_mem[dmem_addr[AW-1:1]];
                busy = 1'b0;
            end else begin
                cur_cnt++;
            end
        end else begin
            busy = 1'b0;
        end
    end

    // Retire monitor.
    always @(negedge clk) begin
        res_t r;
        if (reset_n && done) begin
            if (res_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                r = res_q.pop_front();
                chk("rdata_out", rdata_out, r.rd);
                chk("err", err, r.err);
            end
            chk("stall_in_done", stall, 0);
        end
    end

    task automatic run(input logic [3:0] op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int l1, input int l2);
        int el, cyc;
        bit got, m;
        model(op, a, wd, l1, l2, el);
        m = is_mem_op(op);
        @(posedge clk); #1;
        start = 1'b1; opcode = op; addr = a; wdata = wd;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else begin
                chk("stall", stall, (cyc == 0) ? m : 1'b1);
                @(posedge clk); #1;
                // Garbage on the request lines once the instruction has been accepted.
                start = 1'($urandom); opcode = 4'($urandom); addr = AW'($urandom); wdata = DW'($urandom);
                cyc++;
            end
        end
        if (!got) chk("done_wait_expired", 0, 1);
        else      chk("latency", cyc, el);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int el;
        logic [DW-1:0] v;
        for (int i = 0; i < 32768; i++) begin
            v = DW'($urandom);
            ref_mem[i] = v; bus_mem[i] = v;
        end
        start = 1'b1; opcode = LDR;
        #1;
        chk("reset_outputs", {dmem_addr, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
                              rdata_out, done, stall, err}, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        setmem(16'h1234, 16'hBEEF);
        setmem(16'h2000, 16'h7F80);
        setmem(16'h3000, 16'h4002);
        setmem(16'h4002, 16'h1111);
        run(LDR, 16'h1235, 16'h0000, 2, 0);
        chk("ldr_value", rdata_out, 16'hBEEF);
        run(STB, 16'h0101, 16'h00A5, 1, 0);
        chk("stb_mem", bus_mem[16'h0080][15:8], 8'hA5);
        run(LDB, 16'h2001, 16'h0000, 1, 0);
        chk("ldb_value", rdata_out, 16'h007F);
        run(LDI, 16'h3000, 16'h0000, 1, 1);
        chk("ldi_value", rdata_out, 16'h1111);
        setmem(16'h3000, 16'h5003);
        run(STI, 16'h3000, 16'h2222, 1, 1);
        chk("sti_mem", bus_mem[16'h2801], 16'h2222);
        run(4'd1, 16'h1234, 16'h0000, 0, 0);
        run(LDR, 16'h1234, 16'h0000, 9, 0);
        run(LDI, 16'h3000, 16'h0000, 0, 9);
        run(STR, 16'h0200, 16'h3C3C, WL - 1, 0);

        // Reset in the middle of the second phase of an LDI.
        setmem(16'h3000, 16'h4002);
        model(LDI, 16'h3000, 16'h0000, 1, 3, el);
        void'(res_q.pop_back());
        prev_rd = '0;
        @(posedge clk); #1;
        start = 1'b1; opcode = LDI; addr = 16'h3000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("ph2_read", {dmem_read, stall, dmem_addr}, {2'b11, 16'h4002});
        reset_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {dmem_addr, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
                                  rdata_out, done, stall, err}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("reset_drained", acc_q.size(), 0);
        run(LDR, 16'h4002, 16'h0000, 1, 0);
        chk("post_reset_ldr", rdata_out, 16'h1111);

        for (int t = 0; t < 300; t++) begin
            logic [3:0] op;
            case ($urandom_range(0, 7))
                0: op = LDB; 1: op = STB; 2: op = LDR; 3: op = STR;
                4: op = LDI; 5: op = STI; default: op = 4'($urandom);
            endcase
            run(op, AW'($urandom), DW'($urandom), pick_lat(), pick_lat());
        end

        repeat (3) @(posedge clk);
        chk("access_queue_empty", acc_q.size(), 0);
        chk("result_queue_empty", res_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
